// File: rtl/deserializer_n.sv
// deserializer_n: serial-to-parallel converter feeding a first-word-fall-through
// word FIFO. Bits are gathered MSB-first or LSB-first into a WIDTH-bit word,
// every completed word is queued, and a consumer drains the queue with ack_in.
module deserializer_n #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic                       clk_100mhz,
   input  logic                       reset,
   input  logic                       data_in,
   input  logic                       write_in,
   input  logic                       flush_in,
   input  logic                       ack_in,
   output logic [WIDTH-1:0]           data_out,
   output logic                       data_ready,
   output logic                       status_out,
   output logic [$clog2(DEPTH):0]     count_out,
   output logic                       overrun_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(WIDTH);

   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]    bitCnt_q, bitCnt_d;
   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overrun_q, overrun_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             fifoFull;
   logic             fifoEmpty;
   logic             bitAccept;
   logic             bitDropped;
   logic             lastBit;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] nextShift;

   // Decode FIFO state and the per-cycle events from registered state only;
   // the shifted word already includes the bit being sampled this cycle.
   always_comb begin
      fifoFull   = (count_q == CW'(DEPTH));
      fifoEmpty  = (count_q == '0);
      bitAccept  = write_in && !fifoFull && !flush_in;
      bitDropped = write_in && fifoFull && !flush_in;
      lastBit    = (bitCnt_q == BW'(WIDTH - 1));
      push       = bitAccept && lastBit;
      pop        = ack_in && !fifoEmpty;
      if (LSB_FIRST) begin
         nextShift = {data_in, shift_q[WIDTH-1:1]};
      end else begin
         nextShift = {shift_q[WIDTH-2:0], data_in};
      end
   end

   // Next-state logic for the assembler, the pointers, the occupancy count
   // and the sticky overrun flag. Flush only touches the partial word.
   always_comb begin
      shift_d   = shift_q;
      bitCnt_d  = bitCnt_q;
      wrPtr_d   = wrPtr_q;
      rdPtr_d   = rdPtr_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      if (flush_in) begin
         shift_d  = '0;
         bitCnt_d = '0;
      end else if (bitAccept) begin
         if (lastBit) begin
            shift_d  = '0;
            bitCnt_d = '0;
            wrPtr_d  = wrPtr_q + AW'(1);
         end else begin
            shift_d  = nextShift;
            bitCnt_d = bitCnt_q + BW'(1);
         end
      end
      if (bitDropped) begin
         overrun_d = 1'b1;
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk_100mhz) begin
      if (reset) begin
         shift_q   <= '0;
         bitCnt_q  <= '0;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         bitCnt_q  <= bitCnt_d;
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // Word storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk_100mhz) begin
      if (!reset && push) begin
         mem_q[wrPtr_q] <= nextShift;
      end
   end

   assign data_ready  = !fifoEmpty;
   assign status_out  = !fifoFull;
   assign count_out   = count_q;
   assign overrun_out = overrun_q;
   assign data_out    = fifoEmpty ? '0 : mem_q[rdPtr_q];

endmodule

// File: tb/tb_deserializer_n.sv
// tb_deserializer_n: scoreboard bench for deserializer_n. Words are queued as
// their bits are driven and compared as the FIFO presents them; a second
// instance covers LSB-first assembly.
module tb_deserializer_n;

   logic       clk = 1'b0;
   logic       reset;
   logic       din, wr, fl, ack;
   logic [7:0] dataOut;
   logic       ready, status, overrun;
   logic [2:0] count;

   logic       dinL, wrL, flL, ackL;
   logic [7:0] dataOutL;
   logic       readyL, statusL, overrunL;
   logic [2:0] countL;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] sbq [$];
   logic [7:0] expWord;

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   deserializer_n #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(1'b0)) dutMsb (
      .clk_100mhz(clk), .reset(reset), .data_in(din), .write_in(wr),
      .flush_in(fl), .ack_in(ack), .data_out(dataOut), .data_ready(ready),
      .status_out(status), .count_out(count), .overrun_out(overrun));

   deserializer_n #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(1'b1)) dutLsb (
      .clk_100mhz(clk), .reset(reset), .data_in(dinL), .write_in(wrL),
      .flush_in(flL), .ack_in(ackL), .data_out(dataOutL), .data_ready(readyL),
      .status_out(statusL), .count_out(countL), .overrun_out(overrunL));

   // Inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sbq.delete();
   endtask

   task automatic sendBit(input logic b);
      din = b;
      wr  = 1'b1;
      tick();
      wr  = 1'b0;
   endtask

   task automatic sendWord(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) sendBit(w[i]);
      sbq.push_back(w);
   endtask

   task automatic test_reset();
      pulseReset();
      tests++; if (dataOut !== 8'h00) begin fails++; $display("[TB] FAIL reset_data got %h exp 00", dataOut); end
      tests++; if (ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready got %b exp 0", ready); end
      tests++; if (status !== 1'b1) begin fails++; $display("[TB] FAIL reset_status got %b exp 1", status); end
      tests++; if (count !== 3'd0) begin fails++; $display("[TB] FAIL reset_count got %0d exp 0", count); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL reset_overrun got %b exp 0", overrun); end
   endtask

   task automatic test_msb_basic();
      sendWord(8'hA5);
      expWord = sbq.pop_front();
      tests++; if (dataOut !== expWord) begin fails++; $display("[TB] FAIL msb_data got %h exp %h", dataOut, expWord); end
      tests++; if (ready !== 1'b1) begin fails++; $display("[TB] FAIL msb_ready got %b exp 1", ready); end
      tests++; if (count !== 3'd1) begin fails++; $display("[TB] FAIL msb_count got %0d exp 1", count); end
      ack = 1'b1; tick(); ack = 1'b0;
      tests++; if (ready !== 1'b0) begin fails++; $display("[TB] FAIL msb_ack_ready got %b exp 0", ready); end
      tests++; if (dataOut !== 8'h00) begin fails++; $display("[TB] FAIL msb_ack_data got %h exp 00", dataOut); end
      ack = 1'b1; tick(); ack = 1'b0;
      tests++; if (count !== 3'd0) begin fails++; $display("[TB] FAIL ack_empty_count got %0d exp 0", count); end
   endtask

   task automatic test_lsb_first();
      logic [7:0] bits;
      bits = 8'b1100_0000;
      for (int i = 7; i >= 0; i--) begin
         dinL = bits[i]; wrL = 1'b1; tick(); wrL = 1'b0;
      end
      tests++; if (dataOutL !== 8'h03) begin fails++; $display("[TB] FAIL lsb_data got %h exp 03", dataOutL); end
      tests++; if (readyL !== 1'b1) begin fails++; $display("[TB] FAIL lsb_ready got %b exp 1", readyL); end
      ackL = 1'b1; tick(); ackL = 1'b0;
      tests++; if (countL !== 3'd0) begin fails++; $display("[TB] FAIL lsb_ack_count got %0d exp 0", countL); end
   endtask

   task automatic test_fill_overrun();
      pulseReset();
      sendWord(8'h11); sendWord(8'h22); sendWord(8'h33); sendWord(8'h44);
      tests++; if (count !== 3'd4) begin fails++; $display("[TB] FAIL full_count got %0d exp 4", count); end
      tests++; if (status !== 1'b0) begin fails++; $display("[TB] FAIL full_status got %b exp 0", status); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL pre_overrun got %b exp 0", overrun); end
      sendBit(1'b1);
      tests++; if (overrun !== 1'b1) begin fails++; $display("[TB] FAIL overrun_set got %b exp 1", overrun); end
      for (int i = 0; i < 7; i++) sendBit(i[0]);
      tests++; if (count !== 3'd4) begin fails++; $display("[TB] FAIL overrun_count got %0d exp 4", count); end
      for (int k = 0; k < 4; k++) begin
         expWord = sbq.pop_front();
         tests++; if (dataOut !== expWord) begin fails++; $display("[TB] FAIL drain_%0d got %h exp %h", k, dataOut, expWord); end
         ack = 1'b1; tick(); ack = 1'b0;
         if (k == 0) begin
            tests++; if (status !== 1'b1) begin fails++; $display("[TB] FAIL status_after_pop got %b exp 1", status); end
         end
      end
      tests++; if (ready !== 1'b0) begin fails++; $display("[TB] FAIL drained_ready got %b exp 0", ready); end
      tests++; if (overrun !== 1'b1) begin fails++; $display("[TB] FAIL overrun_sticky got %b exp 1", overrun); end
      sendWord(8'h96);
      expWord = sbq.pop_front();
      tests++; if (dataOut !== expWord) begin fails++; $display("[TB] FAIL partial_clean got %h exp %h", dataOut, expWord); end
      ack = 1'b1; tick(); ack = 1'b0;
   endtask

   task automatic test_push_pop();
      logic [7:0] w;
      pulseReset();
      sendWord(8'hC1); sendWord(8'hC2);
      w = 8'hC3;
      for (int i = 7; i >= 1; i--) sendBit(w[i]);
      din = w[0]; wr = 1'b1; ack = 1'b1;
      tick();
      wr = 1'b0; ack = 1'b0;
      sbq.push_back(w);
      void'(sbq.pop_front());
      tests++; if (count !== 3'd2) begin fails++; $display("[TB] FAIL pushpop_count got %0d exp 2", count); end
      for (int k = 0; k < 2; k++) begin
         expWord = sbq.pop_front();
         tests++; if (dataOut !== expWord) begin fails++; $display("[TB] FAIL pushpop_head_%0d got %h exp %h", k, dataOut, expWord); end
         ack = 1'b1; tick(); ack = 1'b0;
      end
   endtask

   task automatic test_flush();
      pulseReset();
      sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
      din = 1'b1; wr = 1'b1; fl = 1'b1;
      tick();
      wr = 1'b0; fl = 1'b0;
      sendWord(8'h3C);
      expWord = sbq.pop_front();
      tests++; if (dataOut !== expWord) begin fails++; $display("[TB] FAIL flush_data got %h exp %h", dataOut, expWord); end
      tests++; if (count !== 3'd1) begin fails++; $display("[TB] FAIL flush_count got %0d exp 1", count); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL flush_overrun got %b exp 0", overrun); end
      fl = 1'b1; ack = 1'b1; tick(); fl = 1'b0; ack = 1'b0;
      tests++; if (ready !== 1'b0) begin fails++; $display("[TB] FAIL flush_ack_ready got %b exp 0", ready); end
   endtask

   task automatic test_reset_mid();
      pulseReset();
      sendWord(8'h12); sendWord(8'h34);
      for (int i = 0; i < 5; i++) sendBit(1'b1);
      pulseReset();
      tests++; if (count !== 3'd0) begin fails++; $display("[TB] FAIL midreset_count got %0d exp 0", count); end
      tests++; if (dataOut !== 8'h00) begin fails++; $display("[TB] FAIL midreset_data got %h exp 00", dataOut); end
      tests++; if (status !== 1'b1) begin fails++; $display("[TB] FAIL midreset_status got %b exp 1", status); end
      sendWord(8'h5A);
      expWord = sbq.pop_front();
      tests++; if (count !== 3'd1) begin fails++; $display("[TB] FAIL midreset_words got %0d exp 1", count); end
      tests++; if (dataOut !== expWord) begin fails++; $display("[TB] FAIL midreset_word got %h exp %h", dataOut, expWord); end
      ack = 1'b1; tick(); ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      pulseReset();
      for (int k = 0; k < 3; k++) sendWord(8'($urandom_range(0, 255)));
      tests++; if (count !== 3'd3) begin fails++; $display("[TB] FAIL b2b_count got %0d exp 3", count); end
      for (int k = 0; k < 3; k++) begin
         expWord = sbq.pop_front();
         tests++; if (dataOut !== expWord) begin fails++; $display("[TB] FAIL b2b_word_%0d got %h exp %h", k, dataOut, expWord); end
         ack = 1'b1; tick(); ack = 1'b0;
      end
      tests++; if (ready !== 1'b0) begin fails++; $display("[TB] FAIL b2b_empty got %b exp 0", ready); end
   endtask

   // Run the scenarios in order and report a single summary
   initial begin
      reset = 1'b1;
      din = 1'b0; wr = 1'b0; fl = 1'b0; ack = 1'b0;
      dinL = 1'b0; wrL = 1'b0; flL = 1'b0; ackL = 1'b0;
      tick();
      test_reset();
      test_msb_basic();
      test_lsb_first();
      test_fill_overrun();
      test_push_pop();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
